// File: rtl/cursor_controller.sv
// Frame-synchronous cursor controller: debounced-by-frame moves with hold-to-repeat and a select handshake.
// Optional macro CURSOR_WRAP_EN: wrap at grid edges instead of saturating.
module cursor_controller #(
    parameter int GRID_MAX     = 7,
    parameter int INIT_I       = 0,
    parameter int INIT_J       = 0,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic       vsync,
    output logic [2:0] i_actual,
    output logic [2:0] j_actual,
    output logic       frame_tick,
    output logic       sel_valid,
    output logic [2:0] sel_i,
    output logic [2:0] sel_j,
    input  logic       sel_ready
);

    localparam int MAXCNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW     = ($clog2(MAXCNT + 1) > 5) ? $clog2(MAXCNT + 1) : 5;

    localparam logic [2:0]    GMAX    = 3'(GRID_MAX);
    localparam logic [2:0]    INIT_I3 = 3'(INIT_I);
    localparam logic [2:0]    INIT_J3 = 3'(INIT_J);
    localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    logic [4:0] btnRaw;
    logic [4:0] btnSync1_q, btnSync2_q, btnPrev_q;
    logic [4:0] btnRise;

    logic vs_q, tick_q;

    state_t        state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic          pending_q, pending_d;
    logic          setPending;
    logic          dirHeld;

    logic [2:0] i_q, i_d, j_q, j_d;
    logic       selValid_q, selValid_d;
    logic [2:0] selI_q, selI_d, selJ_q, selJ_d;

    assign btnRaw  = {btn_sel, btn_right, btn_left, btn_down, btn_up};
    assign btnRise = btnSync2_q & ~btnPrev_q;

    function automatic logic [2:0] stepUp(input logic [2:0] c);
`ifdef CURSOR_WRAP_EN
        return (c == GMAX) ? 3'd0 : c + 3'd1;
`else
        return (c == GMAX) ? c : c + 3'd1;
`endif
    endfunction

    function automatic logic [2:0] stepDown(input logic [2:0] c);
`ifdef CURSOR_WRAP_EN
        return (c == 3'd0) ? GMAX : c - 3'd1;
`else
        return (c == 3'd0) ? c : c - 3'd1;
`endif
    endfunction

    // Buttons are asynchronous: two-flop synchronizer, then a registered copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btnSync1_q <= '0;
            btnSync2_q <= '0;
            btnPrev_q  <= '0;
        end else begin
            btnSync1_q <= btnRaw;
            btnSync2_q <= btnSync1_q;
            btnPrev_q  <= btnSync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            vs_q   <= vsync;
            tick_q <= vs_q & ~vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_q      <= DIR_UP;
            fcnt_q     <= '0;
            pending_q  <= 1'b0;
            i_q        <= INIT_I3;
            j_q        <= INIT_J3;
            selValid_q <= 1'b0;
            selI_q     <= 3'd0;
            selJ_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            fcnt_q     <= fcnt_d;
            pending_q  <= pending_d;
            i_q        <= i_d;
            j_q        <= j_d;
            selValid_q <= selValid_d;
            selI_q     <= selI_d;
            selJ_q     <= selJ_d;
        end
    end

    always_comb begin
        dirHeld = 1'b0;
        case (dir_q)
            DIR_UP:    dirHeld = btnSync2_q[0];
            DIR_DOWN:  dirHeld = btnSync2_q[1];
            DIR_LEFT:  dirHeld = btnSync2_q[2];
            DIR_RIGHT: dirHeld = btnSync2_q[3];
            default:   dirHeld = 1'b0;
        endcase
    end

    // The repeat counter only advances on frame ticks; reaching the threshold is acted on the cycle after.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        fcnt_d     = fcnt_q;
        setPending = 1'b0;
        case (state_q)
            IDLE: begin
                if (|btnRise[3:0]) begin
                    setPending = 1'b1;
                    fcnt_d     = '0;
                    state_d    = HELD;
                    if (btnRise[0])      dir_d = DIR_UP;
                    else if (btnRise[1]) dir_d = DIR_DOWN;
                    else if (btnRise[2]) dir_d = DIR_LEFT;
                    else                 dir_d = DIR_RIGHT;
                end
            end
            HELD: begin
                if (!dirHeld) begin
                    state_d = IDLE;
                end else if (fcnt_q == DELAY_C) begin
                    setPending = 1'b1;
                    fcnt_d     = '0;
                    state_d    = REPEAT;
                end else if (tick_q) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!dirHeld) begin
                    state_d = IDLE;
                end else if (fcnt_q == RATE_C) begin
                    setPending = 1'b1;
                    fcnt_d     = '0;
                end else if (tick_q) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pending move is consumed on the tick even when it saturates, so it never leaks into the next frame.
    always_comb begin
        pending_d = (pending_q & ~tick_q) | setPending;
        i_d       = i_q;
        j_d       = j_q;
        if (tick_q && pending_q) begin
            case (dir_q)
                DIR_UP:    i_d = stepDown(i_q);
                DIR_DOWN:  i_d = stepUp(i_q);
                DIR_LEFT:  j_d = stepDown(j_q);
                DIR_RIGHT: j_d = stepUp(j_q);
                default: ;
            endcase
        end
    end

    always_comb begin
        selValid_d = selValid_q;
        selI_d     = selI_q;
        selJ_d     = selJ_q;
        if (selValid_q) begin
            if (sel_ready) selValid_d = 1'b0;
        end else if (btnRise[4]) begin
            selValid_d = 1'b1;
            selI_d     = i_q;
            selJ_d     = j_q;
        end
    end

    assign i_actual   = i_q;
    assign j_actual   = j_q;
    assign frame_tick = tick_q;
    assign sel_valid  = selValid_q;
    assign sel_i      = selI_q;
    assign sel_j      = selJ_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Randomized bench for cursor_controller against a frame-level reference model of cursor movement and selection.
module tb_cursor_controller;

    localparam int GMAX = 7;
    localparam int INI  = 3;
    localparam int INJ  = 4;
    localparam int DLY  = 30;
    localparam int RATE = 6;

    logic       clk;
    logic       rst_n;
    logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic       vsync;
    logic [2:0] i_actual, j_actual;
    logic       frame_tick;
    logic       sel_valid;
    logic [2:0] sel_i, sel_j;
    logic       sel_ready;

    int checks = 0;
    int errors = 0;

    int mi, mj;
    bit mSelValid;
    int mSelI, mSelJ;

    logic       monEn = 1'b0;
    logic [2:0] prevI, prevJ;
    logic       prevTick;

    cursor_controller #(
        .GRID_MAX(GMAX), .INIT_I(INI), .INIT_J(INJ),
        .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .vsync(vsync),
        .i_actual(i_actual), .j_actual(j_actual),
        .frame_tick(frame_tick),
        .sel_valid(sel_valid), .sel_i(sel_i), .sel_j(sel_j),
        .sel_ready(sel_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Twenty-clock frames with a four-clock active-low sync pulse.
    initial begin
        vsync = 1'b1;
        forever begin
            repeat (16) @(negedge clk);
            vsync = 1'b0;
            repeat (4) @(negedge clk);
            vsync = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Coordinates may only change on the edge that ends a tick cycle.
    always @(negedge clk) begin
        if (monEn && rst_n && (i_actual !== prevI || j_actual !== prevJ))
            checkOutput("move_off_tick", {31'd0, prevTick}, 32'd1);
        prevI    <= i_actual;
        prevJ    <= j_actual;
        prevTick <= frame_tick;
    end

    function automatic int incModel(input int c);
`ifdef CURSOR_WRAP_EN
        return (c == GMAX) ? 0 : c + 1;
`else
        return (c == GMAX) ? c : c + 1;
`endif
    endfunction

    function automatic int decModel(input int c);
`ifdef CURSOR_WRAP_EN
        return (c == 0) ? GMAX : c - 1;
`else
        return (c == 0) ? c : c - 1;
`endif
    endfunction

    // Held-button schedule: first tick, then DLY ticks later, then every RATE ticks.
    function automatic bit isMoveFrame(input int f);
        return (f == 1) || (f >= 1 + DLY && ((f - 1 - DLY) % RATE) == 0);
    endfunction

    task automatic applyModel(input int d);
        case (d)
            0: mi = decModel(mi);
            1: mi = incModel(mi);
            2: mj = decModel(mj);
            default: mj = incModel(mj);
        endcase
    endtask

    task automatic waitTick();
        int n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tick_seen", {31'd0, frame_tick}, 32'd1);
        @(negedge clk);
        checkOutput("tick_width", {31'd0, frame_tick}, 32'd0);
    endtask

    task automatic waitTickMid();
        waitTick();
        repeat (7) @(negedge clk);
    endtask

    // Press the masked buttons at mid-frame, hold for h ticks, observe h+extra frames.
    task automatic applyStimulus(input logic [3:0] mask, input int h, input int extra);
        int d;
        d = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : 3;
        btn_up    = mask[0];
        btn_down  = mask[1];
        btn_left  = mask[2];
        btn_right = mask[3];
        for (int f = 1; f <= h + extra; f++) begin
            waitTickMid();
            if (f <= h + 1 && isMoveFrame(f)) applyModel(d);
            checkOutput("pos_i", {29'd0, i_actual}, mi);
            checkOutput("pos_j", {29'd0, j_actual}, mj);
            if (f == h) {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        end
    endtask

    task automatic moveTo(input int ti, input int tj);
        while (mi > ti) applyStimulus(4'b0001, 1, 1);
        while (mi < ti) applyStimulus(4'b0010, 1, 1);
        while (mj > tj) applyStimulus(4'b0100, 1, 1);
        while (mj < tj) applyStimulus(4'b1000, 1, 1);
    endtask

    task automatic selOp(input bit doSel, input bit doReady);
        if (doSel) begin
            btn_sel = 1'b1;
            repeat (4) @(negedge clk);
            btn_sel = 1'b0;
            if (!mSelValid) begin
                mSelValid = 1'b1;
                mSelI     = mi;
                mSelJ     = mj;
            end
        end
        checkOutput("sel_valid", {31'd0, sel_valid}, {31'd0, mSelValid});
        if (mSelValid) begin
            checkOutput("sel_i", {29'd0, sel_i}, mSelI);
            checkOutput("sel_j", {29'd0, sel_j}, mSelJ);
        end
        if (doReady) begin
            sel_ready = 1'b1;
            @(negedge clk);
            sel_ready = 1'b0;
            mSelValid = 1'b0;
            checkOutput("sel_clear", {31'd0, sel_valid}, 32'd0);
        end
        waitTickMid();
        checkOutput("pos_i_idle", {29'd0, i_actual}, mi);
        checkOutput("pos_j_idle", {29'd0, j_actual}, mj);
    endtask

    initial begin
        rst_n = 1'b1;
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = 5'b0;
        sel_ready = 1'b0;
        mi = INI; mj = INJ;
        mSelValid = 1'b0; mSelI = 0; mSelJ = 0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_i", {29'd0, i_actual}, INI);
        checkOutput("rst_j", {29'd0, j_actual}, INJ);
        checkOutput("rst_tick", {31'd0, frame_tick}, 32'd0);
        checkOutput("rst_sel_valid", {31'd0, sel_valid}, 32'd0);
        checkOutput("rst_sel_i", {29'd0, sel_i}, 32'd0);
        checkOutput("rst_sel_j", {29'd0, sel_j}, 32'd0);
        rst_n = 1'b1;
        monEn = 1'b1;
        waitTickMid();

        // Single right press, then quiet frames.
        applyStimulus(4'b1000, 1, 3);

        // Simultaneous up+left: up wins.
        moveTo(3, 3);
        applyStimulus(4'b0101, 1, 3);

        // Long hold of down from the corner.
        moveTo(0, 0);
        applyStimulus(4'b0010, 50, 2);

        // Right edge behaviour.
        moveTo(0, 7);
        applyStimulus(4'b1000, 1, 3);

        // Select handshake: second select while offered is dropped.
        moveTo(2, 5);
        selOp(1'b1, 1'b0);
        applyStimulus(4'b1000, 1, 1);
        selOp(1'b1, 1'b0);
        selOp(1'b0, 1'b1);

        // Reset while a move is pending and a selection is offered, with left held through reset.
        waitTick();
        btn_left = 1'b1;
        btn_sel  = 1'b1;
        repeat (4) @(negedge clk);
        btn_sel = 1'b0;
        checkOutput("pre_rst_sel", {31'd0, sel_valid}, 32'd1);
        monEn = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mi = INI; mj = INJ; mSelValid = 1'b0;
        checkOutput("async_rst_i", {29'd0, i_actual}, mi);
        checkOutput("async_rst_j", {29'd0, j_actual}, mj);
        checkOutput("async_rst_sel", {31'd0, sel_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        monEn = 1'b1;
        applyStimulus(4'b0100, 1, 3);
        checkOutput("post_rst_sel", {31'd0, sel_valid}, 32'd0);

        for (int k = 0; k < 25; k++) begin
            logic [3:0] mask;
            int h;
            mask = 4'($urandom_range(1, 15));
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 40) : $urandom_range(1, 4);
            applyStimulus(mask, h, $urandom_range(1, 2));
            selOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
